// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; the pipeline is held via o_stall while the division runs.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed_div,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic             i_annul,
    output logic             o_stall,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_negQ;
    logic             r_negR;

    logic             w_accept;
    logic             w_divZero;
    logic             w_lastIter;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    assign w_accept   = (r_state == S_IDLE) && i_start && !i_annul;
    assign w_divZero  = (i_opb == '0);
    assign w_lastIter = (r_count == CW'(WIDTH - 1));
    assign w_absA     = (i_signed_div && i_opa[WIDTH-1]) ? -i_opa : i_opa;
    assign w_absB     = (i_signed_div && i_opb[WIDTH-1]) ? -i_opb : i_opb;

    // Partial remainder is one bit wider so a borrow out of the trial subtract shows as the sign.
    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_div};
    assign w_remNext  = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quoNext  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_divZero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_annul) begin
                    w_next = S_IDLE;
                end else if (w_lastIter) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Results are committed on the edge into DONE, so hi/lo are already valid while ready is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_absA;
                        r_div   <= w_absB;
                        r_negQ  <= i_signed_div && (i_opa[WIDTH-1] != i_opb[WIDTH-1]);
                        r_negR  <= i_signed_div && i_opa[WIDTH-1];
                        if (w_divZero) begin
                            r_hi <= i_opa;
                            r_lo <= '1;
                        end
                    end
                end
                S_BUSY: begin
                    if (!i_annul) begin
                        r_rem   <= w_remNext;
                        r_quo   <= w_quoNext;
                        r_count <= r_count + CW'(1);
                        if (w_lastIter) begin
                            r_lo <= r_negQ ? -w_quoNext : w_quoNext;
                            r_hi <= r_negR ? -w_remNext : w_remNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_stall = w_accept || (r_state == S_BUSY);
    assign o_ready = (r_state == S_DONE);
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

endmodule
